// File: rtl/cic3_row_readout_sched.sv
// cic3_row_readout_sched
// Snapshots a row of CIC3 filter outputs on each decimation strobe and drains
// the enabled channels, lowest index first, onto one valid/ready stream.
// Optional build macro CIC3_READOUT_HEADER_EN adds a header word carrying the
// frame count ahead of the channel words. Without it the HDR state does not exist.
module cic3_row_readout_sched #(
    parameter int NUM_FILTERS = 24,
    parameter int OUT_WIDTH   = 25,
    parameter int CHAN_W      = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sample_strobe,
    input  logic [NUM_FILTERS*OUT_WIDTH-1:0] filt_data,
    input  logic [NUM_FILTERS-1:0]           chan_en,
    input  logic                             dout_ready,
    output logic                             dout_valid,
    output logic [OUT_WIDTH-1:0]             dout_data,
    output logic [CHAN_W-1:0]                dout_chan,
    output logic                             dout_last,
    output logic                             busy,
    output logic [15:0]                      frame_cnt,
    output logic                             overrun,
    input  logic                             overrun_clr,
    output logic [7:0]                       drop_cnt
);

`ifdef CIC3_READOUT_HEADER_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HDR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CHAN_W-1:0]      ptr_q, ptr_d;
    logic [NUM_FILTERS-1:0] mask_q, mask_d;
    logic [OUT_WIDTH-1:0]   snap_q [NUM_FILTERS];
    logic [OUT_WIDTH-1:0]   snap_d [NUM_FILTERS];
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic                   busy_q, busy_d;

    logic                   handshake;
    logic                   frame_done;
    logic                   accept;
    logic                   drop;
    logic [NUM_FILTERS-1:0] higher_mask;

    assign handshake = dout_valid & dout_ready;

    // State register plus all datapath flops, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            mask_q      <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            drop_cnt_q  <= '0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            drop_cnt_q  <= drop_cnt_d;
            busy_q      <= busy_d;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    // Next state and pointer; a strobe in the completing cycle starts the next frame
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                ptr_d = ptr_q;
            end
`ifdef CIC3_READOUT_HEADER_EN
            HDR: begin
                if (handshake) begin
                    ptr_d = '0;
                    if (mask_q == '0) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
`endif
            SCAN: begin
                if (!mask_q[ptr_q] || handshake) begin
                    if (ptr_q == CHAN_W'(NUM_FILTERS - 1)) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                        ptr_d      = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
        accept = sample_strobe && ((state_q == IDLE) || frame_done);
        if (accept) begin
            ptr_d = '0;
`ifdef CIC3_READOUT_HEADER_EN
            state_d = HDR;
`else
            state_d = SCAN;
`endif
        end
    end

    // Snapshot, counters and sticky overrun; a clear applies before a same-cycle drop
    always_comb begin
        mask_d      = mask_q;
        frame_cnt_d = frame_cnt_q;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            snap_d[k] = accept ? filt_data[k*OUT_WIDTH +: OUT_WIDTH] : snap_q[k];
        end
        if (accept) begin
            mask_d      = chan_en;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        drop       = sample_strobe & ~accept;
        overrun_d  = overrun_clr ? 1'b0 : overrun_q;
        drop_cnt_d = overrun_clr ? 8'd0 : drop_cnt_q;
        if (drop) begin
            overrun_d = 1'b1;
            if (drop_cnt_d != 8'hFF) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
        end
        busy_d = (state_d != IDLE);
    end

    // Stream outputs decoded from registered state only, never from dout_ready
    always_comb begin
        dout_valid  = 1'b0;
        dout_data   = '0;
        dout_chan   = '0;
        dout_last   = 1'b0;
        higher_mask = (mask_q >> ptr_q) >> 1;
        case (state_q)
`ifdef CIC3_READOUT_HEADER_EN
            HDR: begin
                dout_valid = 1'b1;
                dout_data  = OUT_WIDTH'(frame_cnt_q);
                dout_chan  = '1;
                dout_last  = (mask_q == '0);
            end
`endif
            SCAN: begin
                dout_valid = mask_q[ptr_q];
                dout_data  = snap_q[ptr_q];
                dout_chan  = ptr_q;
                dout_last  = mask_q[ptr_q] && (higher_mask == '0);
            end
            default: begin
                dout_valid = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cic3_row_readout_sched.sv
// Testbench for cic3_row_readout_sched: frame-level behavioural model checked
// every cycle, plus hand-computed literal expectations for the directed tests.
module tb_cic3_row_readout_sched;

    localparam int N  = 24;
    localparam int W  = 25;
    localparam int CW = 5;
`ifdef CIC3_READOUT_HEADER_EN
    localparam int HDR_EN = 1;
`else
    localparam int HDR_EN = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             sample_strobe;
    logic [N*W-1:0]   filt_data;
    logic [N-1:0]     chan_en;
    logic             dout_ready;
    logic             dout_valid;
    logic [W-1:0]     dout_data;
    logic [CW-1:0]    dout_chan;
    logic             dout_last;
    logic             busy;
    logic [15:0]      frame_cnt;
    logic             overrun;
    logic             overrun_clr;
    logic [7:0]       drop_cnt;

    cic3_row_readout_sched #(.NUM_FILTERS(N), .OUT_WIDTH(W), .CHAN_W(CW)) dut (
        .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .filt_data(filt_data),
        .chan_en(chan_en), .dout_ready(dout_ready), .dout_valid(dout_valid),
        .dout_data(dout_data), .dout_chan(dout_chan), .dout_last(dout_last),
        .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun),
        .overrun_clr(overrun_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [W-1:0]  data;
        logic          last;
    } word_t;
    word_t words[$];

    // Frame-level model state
    bit             started = 0;
    bit             m_in_frame;
    bit             m_hdr;
    int             m_pos;
    logic [W-1:0]   m_snap [N];
    logic [N-1:0]   m_mask;
    int             m_fc;
    int             m_drops;
    bit             m_ov;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit m_higher_empty();
        for (int j = m_pos + 1; j < N; j++) begin
            if (m_mask[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit m_exp_valid();
        return m_in_frame && (m_hdr || m_mask[m_pos]);
    endfunction

    function automatic bit m_completing(input bit rdy);
        if (!m_in_frame) return 1'b0;
        if (m_hdr) return rdy && (m_mask == '0);
        return (m_pos == N - 1) && (!m_mask[m_pos] || rdy);
    endfunction

    // Model update on each rising edge from the inputs held across that edge
    always @(posedge clk) begin
        bit done;
        bit acc;
        if (reset) begin
            started    = 1;
            m_in_frame = 0;
            m_hdr      = 0;
            m_pos      = 0;
            m_mask     = '0;
            m_fc       = 0;
            m_drops    = 0;
            m_ov       = 0;
            for (int k = 0; k < N; k++) m_snap[k] = '0;
        end else begin
            done = m_completing(dout_ready);
            acc  = sample_strobe && (!m_in_frame || done);
            if (m_in_frame && !done) begin
                if (m_hdr) begin
                    if (dout_ready) begin
                        m_hdr = 0;
                        m_pos = 0;
                    end
                end else if (!m_mask[m_pos] || dout_ready) begin
                    m_pos++;
                end
            end
            if (done) m_in_frame = 0;
            if (overrun_clr) begin
                m_ov    = 0;
                m_drops = 0;
            end
            if (sample_strobe && !acc) begin
                m_ov = 1;
                if (m_drops < 255) m_drops++;
            end
            if (acc) begin
                for (int k = 0; k < N; k++) m_snap[k] = filt_data[k*W +: W];
                m_mask     = chan_en;
                m_fc       = (m_fc + 1) % 65536;
                m_pos      = 0;
                m_in_frame = 1;
                m_hdr      = (HDR_EN != 0);
            end
        end
    end

    // Compare DUT against the model on every falling edge and log handshakes
    always @(negedge clk) begin
        if (started) begin
            bit ev;
            ev = m_exp_valid();
            checkOutput("busy", busy, m_in_frame);
            checkOutput("frame_cnt", frame_cnt, m_fc);
            checkOutput("overrun", overrun, m_ov);
            checkOutput("drop_cnt", drop_cnt, m_drops);
            checkOutput("dout_valid", dout_valid, ev);
            if (ev) begin
                checkOutput("dout_chan", dout_chan, m_hdr ? 31 : m_pos);
                checkOutput("dout_data", dout_data, m_hdr ? m_fc : m_snap[m_pos]);
                checkOutput("dout_last", dout_last, m_hdr ? (m_mask == '0) : m_higher_empty());
            end else if (!m_in_frame) begin
                checkOutput("idle_data", dout_data, 0);
                checkOutput("idle_chan", dout_chan, 0);
                checkOutput("idle_last", dout_last, 0);
            end else begin
                checkOutput("skip_last", dout_last, 0);
            end
            if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
                words.push_back('{chan: dout_chan, data: dout_data, last: dout_last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Load filter words base+k and the mask, then pulse the strobe for one cycle
    task automatic applyStimulus(input logic [N-1:0] en, input int base);
        for (int k = 0; k < N; k++) filt_data[k*W +: W] = W'(base + k);
        chan_en       = en;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic waitIdle(input string name, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        if (cycles >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout actual=busy expected=idle", name);
        end
    endtask

    initial begin
        int cyc;
        int cnt;
        reset         = 1'b1;
        sample_strobe = 1'b0;
        overrun_clr   = 1'b0;
        dout_ready    = 1'b0;
        chan_en       = '0;
        filt_data     = '0;
        repeat (3) tick();
        reset = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", dout_valid, 0);
        checkOutput("reset_frame_cnt", frame_cnt, 0);

        // Full mask, always ready: 24 consecutive words
        $display("[TB] full-mask frame");
        dout_ready = 1'b1;
        words.delete();
        applyStimulus('1, 'h100);
        waitIdle("t1_idle", cyc);
        checkOutput("t1_word_count", words.size(), N + HDR_EN);
        if (words.size() == N + HDR_EN) begin
            checkOutput("t1_first_chan", words[HDR_EN].chan, 0);
            checkOutput("t1_first_data", words[HDR_EN].data, 'h100);
            checkOutput("t1_final_chan", words[N+HDR_EN-1].chan, 23);
            checkOutput("t1_final_data", words[N+HDR_EN-1].data, 'h117);
            checkOutput("t1_final_last", words[N+HDR_EN-1].last, 1);
            checkOutput("t1_prev_last", words[N+HDR_EN-2].last, 0);
`ifdef CIC3_READOUT_HEADER_EN
            checkOutput("t1_hdr_chan", words[0].chan, 'h1F);
            checkOutput("t1_hdr_data", words[0].data, 1);
`endif
        end
        checkOutput("t1_frame_cnt", frame_cnt, 1);

        // Sparse mask 0x000005 with ready toggling
        $display("[TB] sparse mask with toggling ready");
        words.delete();
        applyStimulus(24'h000005, 'h200);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            tick();
            cnt++;
            dout_ready = ~dout_ready;
        end
        dout_ready = 1'b1;
`ifndef CIC3_READOUT_HEADER_EN
        checkOutput("t2_frame_len", cnt, 24);
`endif
        checkOutput("t2_word_count", words.size(), 2 + HDR_EN);
        if (words.size() == 2 + HDR_EN) begin
            checkOutput("t2_w0_chan", words[HDR_EN].chan, 0);
            checkOutput("t2_w0_data", words[HDR_EN].data, 'h200);
            checkOutput("t2_w0_last", words[HDR_EN].last, 0);
            checkOutput("t2_w1_chan", words[HDR_EN+1].chan, 2);
            checkOutput("t2_w1_data", words[HDR_EN+1].data, 'h202);
            checkOutput("t2_w1_last", words[HDR_EN+1].last, 1);
        end

        // Strobe five cycles into a frame is dropped
        $display("[TB] overrun mid-frame");
        words.delete();
        applyStimulus('1, 'h300);
        repeat (4) tick();
        applyStimulus('0, 'h400);
        checkOutput("t3_overrun", overrun, 1);
        checkOutput("t3_drop_cnt", drop_cnt, 1);
        checkOutput("t3_frame_cnt", frame_cnt, 3);
        waitIdle("t3_idle", cyc);
        checkOutput("t3_word_count", words.size(), N + HDR_EN);
        if (words.size() == N + HDR_EN) begin
            checkOutput("t3_final_data", words[N+HDR_EN-1].data, 'h317);
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checkOutput("t3_clr_overrun", overrun, 0);
        checkOutput("t3_clr_drop_cnt", drop_cnt, 0);

        // Strobe exactly in the completion cycle starts the next frame
        $display("[TB] back-to-back frames");
        applyStimulus('1, 'h500);
        cnt = 0;
        while (!m_completing(dout_ready) && cnt < 200) begin
            tick();
            cnt++;
        end
        checkOutput("t4_reach_completion", cnt < 200, 1);
        applyStimulus('1, 'h600);
        checkOutput("t4_overrun", overrun, 0);
        checkOutput("t4_frame_cnt", frame_cnt, 5);
        checkOutput("t4_busy", busy, 1);
        checkOutput("t4_valid", dout_valid, 1);
`ifdef CIC3_READOUT_HEADER_EN
        checkOutput("t4_chan", dout_chan, 'h1F);
`else
        checkOutput("t4_chan", dout_chan, 0);
        checkOutput("t4_data", dout_data, 'h600);
`endif
        // Stall the frame and drop 300 strobes
        dout_ready    = 1'b0;
        sample_strobe = 1'b1;
        repeat (300) tick();
        sample_strobe = 1'b0;
        checkOutput("t4_drop_sat", drop_cnt, 255);
        checkOutput("t4_drop_overrun", overrun, 1);
        checkOutput("t4_drop_frame_cnt", frame_cnt, 5);
        sample_strobe = 1'b1;
        overrun_clr   = 1'b1;
        tick();
        sample_strobe = 1'b0;
        overrun_clr   = 1'b0;
        checkOutput("t4_clr_drop_overrun", overrun, 1);
        checkOutput("t4_clr_drop_cnt", drop_cnt, 1);
        dout_ready = 1'b1;
        waitIdle("t4_idle", cyc);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;

        // Reset mid-frame at ptr=10
        $display("[TB] reset mid-frame");
        applyStimulus('1, 'h700);
        repeat (10 + HDR_EN) tick();
        checkOutput("t5_pre_valid", dout_valid, 1);
        checkOutput("t5_pre_chan", dout_chan, 10);
        reset = 1'b1;
        tick();
        checkOutput("t5_valid", dout_valid, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_frame_cnt", frame_cnt, 0);
        reset = 1'b0;
        tick();

        // Third frame after reset with an all-zero mask
        $display("[TB] all-zero mask frame");
        applyStimulus(24'h000001, 'h800);
        waitIdle("t6_f1_idle", cyc);
        applyStimulus(24'h000001, 'h800);
        waitIdle("t6_f2_idle", cyc);
        words.delete();
        applyStimulus('0, 'h900);
        waitIdle("t6_f3_idle", cyc);
`ifdef CIC3_READOUT_HEADER_EN
        checkOutput("t6_frame_len", cyc, 1);
        checkOutput("t6_word_count", words.size(), 1);
        if (words.size() == 1) begin
            checkOutput("t6_hdr_chan", words[0].chan, 'h1F);
            checkOutput("t6_hdr_data", words[0].data, 3);
            checkOutput("t6_hdr_last", words[0].last, 1);
        end
`else
        checkOutput("t6_frame_len", cyc, 24);
        checkOutput("t6_word_count", words.size(), 0);
`endif
        checkOutput("t6_frame_cnt", frame_cnt, 3);
        checkOutput("t6_busy", busy, 0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic3_row_readout_sched.md
# cic3_row_readout_sched

Readout scheduler for a row of CIC3 decimation filters. On each decimation strobe it snapshots every filter's output word. It then drains the enabled channels in ascending order onto one shared valid/ready stream. This stream is the single path from a filter row to the chip's readout/serializer logic, so a row's filters share one output port.

## Interface

Parameters:
- NUM_FILTERS, 24, filters in the row (max 31)
- OUT_WIDTH, 25, bits per filter output word
- CHAN_W, 5, channel-index width; header code is all-ones

Ports:
- clk  in  1  row clock, the filters' modulator clock
- reset  in  1  synchronous, active-high
- sample_strobe  in  1  one-cycle pulse: filter outputs are valid this cycle (once per decimation period)
- filt_data  in  NUM_FILTERS*OUT_WIDTH  concatenated filter outputs; channel k at [k*OUT_WIDTH +: OUT_WIDTH]
- chan_en  in  NUM_FILTERS  channel enable mask, sampled at strobe acceptance
- dout_ready  in  1  downstream ready
- dout_valid  out  1  word available
- dout_data  out  OUT_WIDTH  word payload
- dout_chan  out  CHAN_W  channel index of the word
- dout_last  out  1  final word of the frame
- busy  out  1  frame in progress (state != IDLE)
- frame_cnt  out  16  accepted frames, wraps at 0xFFFF→0
- overrun  out  1  sticky: a strobe was dropped
- overrun_clr  in  1  clears overrun and drop_cnt
- drop_cnt  out  8  dropped strobes, saturates at 255

## Operation

- States: IDLE, HDR (macro only), SCAN.
- Strobe acceptance happens in either of two cases:
  - sample_strobe while in IDLE;
  - sample_strobe in the cycle that completes the current frame (back-to-back).
- On acceptance:
  - snap[k] ← filt_data word k and mask_q ← chan_en;
  - frame_cnt += 1;
  - ptr ← 0;
  - next state is HDR if the macro is defined, otherwise SCAN.
- SCAN outputs: dout_valid = mask_q[ptr]; dout_data = snap[ptr]; dout_chan = ptr.
- ptr advances when mask_q[ptr]=0 (skip, one cycle) or on a handshake (dout_valid & dout_ready).
- Completion: frame completes when ptr = NUM_FILTERS-1 and the channel is skipped or handshaken. Next state is IDLE, or a new frame if a strobe is accepted that cycle.
- dout_last = dout_valid and no enabled channel above ptr in mask_q.
- Payload is held stable while dout_valid & !dout_ready. Changes to chan_en or filt_data mid-frame have no effect.
- Overrun: a strobe that is not accepted sets overrun and increments drop_cnt (saturating). Snapshot, mask and frame_cnt are unchanged.
- Strobe and overrun_clr in the same cycle with a drop: clear wins for the old state, then the drop is counted. Result is overrun=1, drop_cnt=1.
- All-zero mask (no macro): the frame takes NUM_FILTERS cycles with no valid output.

## Timing

- Reset values:
  - state IDLE; busy=0;
  - dout_valid=0, dout_last=0, dout_data=0, dout_chan=0;
  - frame_cnt=0, overrun=0, drop_cnt=0;
  - ptr=0, snap=0, mask_q=0.
- Reset mid-frame aborts the frame immediately. No further valid is emitted.
- Strobe accepted at edge E: the first SCAN word is valid in the cycle after E, for channel 0 if enabled (no macro).
- Minimum frame length: NUM_FILTERS cycles, plus 1 with the header. Back-to-back frames have no idle gap.
- dout_valid/dout_data/dout_chan/dout_last decode from registered state only, with no path from dout_ready. busy is registered.

## Configuration

- CIC3_READOUT_HEADER_EN defined:
  - HDR state precedes SCAN;
  - one header word is emitted with dout_chan = all-ones and dout_data = frame_cnt (post-increment, zero-extended);
  - HDR is held until handshake, then goes to SCAN with ptr=0;
  - with an all-zero mask, the header carries dout_last=1 and the frame ends after the header handshake.
- Not defined: no HDR state; frames contain channel words only.

## Test plan

- Reset, then strobe with chan_en=all-ones and data word k = k+0x100, dout_ready=1 → 24 consecutive words, chan 0..23, data 0x100..0x117, dout_last only on chan 23, frame_cnt=1.
- chan_en=0x000005 and dout_ready toggled 1/0 → only chan 0 and 2 are emitted, payload stable during stalls, dout_last on chan 2, frame length 24 cycles.
- Second strobe 5 cycles into a frame → overrun=1, drop_cnt=1, frame_cnt unchanged, current frame output unaltered; overrun_clr then gives overrun=0, drop_cnt=0.
- Strobe in the exact completion cycle of a frame → accepted, new frame chan 0 valid next cycle, no overrun; 300 dropped strobes → drop_cnt=255.
- Reset asserted while ptr=10 with dout_valid high → next cycle dout_valid=0, busy=0, frame_cnt=0.
- With CIC3_READOUT_HEADER_EN: third frame, all-zero mask → single word with dout_chan=0x1F, dout_data=3, dout_last=1, then IDLE.
